// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, widths and helpers for the N-way instruction cache
package icache_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        REFILL,
        INVAL,
        FLUSH
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Way-pointer width; a direct-mapped cache still carries a 1-bit pointer.
    function automatic int ptr_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_nway_wb_if.sv
// rtl/icache_nway_wb_if.sv - Wishbone line-refill bus between cache and memory interconnect
interface icache_nway_wb_if
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 16
);
    logic [ADDR_W-1:0]            wb_adr;
    logic [WORD_W*LINE_WORDS-1:0] wb_dat_i;
    logic                         wb_cyc;
    logic                         wb_stb;
    logic                         wb_ack;
    logic                         wb_err;

    modport master (
        output wb_adr, wb_cyc, wb_stb,
        input  wb_dat_i, wb_ack, wb_err
    );

    modport slave (
        input  wb_adr, wb_cyc, wb_stb,
        output wb_dat_i, wb_ack, wb_err
    );
endinterface

// File: rtl/icache_victim_sel.sv
// rtl/icache_victim_sel.sv - per-set round-robin pointer with invalid-way preference
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 512,
    localparam int IDX_W = clog2(SETS),
    localparam int PW    = ptr_w(WAYS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAYS-1:0]  valid,
    input  logic             adv,
    input  logic             clr,
    output logic [PW-1:0]    victim
);

    logic [PW-1:0] rr_mem [SETS];

    // Pointer array: cleared by the init/flush sweep, stepped on each successful fill.
    always_ff @(posedge clk) begin
        if (clr) begin
            rr_mem[idx] <= '0;
        end else if (adv) begin
            rr_mem[idx] <= (rr_mem[idx] == PW'(WAYS - 1)) ? '0 : rr_mem[idx] + PW'(1);
        end
    end

    // Lowest-numbered invalid way wins; otherwise the round-robin pointer picks.
    always_comb begin
        victim = rr_mem[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) victim = PW'(w);
        end
    end

endmodule

// File: rtl/icache_nway_wb.sv
// rtl/icache_nway_wb.sv - N-way set-associative instruction cache with Wishbone line refill
module icache_nway_wb
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 512,
    parameter int LINE_WORDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               req,
    output logic [WORD_W-1:0]  inst,
    output logic               stall,
    input  logic [ADDR_W-1:0]  inv_addr,
    input  logic               inv_req,
    input  logic               inv_all,
    output logic               inv_ack,
    output logic               bus_err,
    icache_nway_wb_if.master   wb
);

    localparam int WD_W  = clog2(LINE_WORDS);
    localparam int OFS_W = WD_W + 2;
    localparam int IDX_W = clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W;
    localparam int LA_W  = TAG_W + IDX_W;
    localparam int LW    = WORD_W * LINE_WORDS;
    localparam int PW    = ptr_w(WAYS);

    // Tag, valid and data arrays; deliberately not reset, the INIT sweep clears valid.
    logic [TAG_W-1:0] tag_mem   [WAYS][SETS];
    logic             valid_mem [WAYS][SETS];
    logic [LW-1:0]    data_mem  [WAYS][SETS];

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [LA_W-1:0]  fill_line;
    logic [PW-1:0]    fill_way;
    logic [IDX_W-1:0] inv_idx;
    logic [TAG_W-1:0] inv_tag;

    logic [IDX_W-1:0] pc_idx, fill_idx, vs_idx;
    logic [TAG_W-1:0] pc_tag, fill_tag;
    logic [WD_W-1:0]  pc_wd;
    logic [WAYS-1:0]  hit_vec, set_valid;
    logic             hit, last_set;
    logic [LW-1:0]    line_sh;
    logic [PW-1:0]    victim;

    logic clr_we, inval_we, fill_we;
    logic go_refill, go_inval, go_flush;
    logic cyc;
    logic unused_addr_bits;

    assign pc_idx   = pc[OFS_W +: IDX_W];
    assign pc_tag   = pc[ADDR_W-1 -: TAG_W];
    assign pc_wd    = pc[OFS_W-1:2];
    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[LA_W-1:IDX_W];
    assign last_set = (cnt == IDX_W'(SETS - 1));

    assign unused_addr_bits = ^{pc[1:0], inv_addr[OFS_W-1:0]};

    // Zero-latency lookup of all ways at the fetch index.
    always_comb begin
        hit_vec   = '0;
        set_valid = '0;
        inst      = '0;
        line_sh   = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_mem[w][pc_idx];
            hit_vec[w]   = valid_mem[w][pc_idx] && (tag_mem[w][pc_idx] == pc_tag);
            if (hit_vec[w]) begin
                line_sh = data_mem[w][pc_idx] >> {pc_wd, 5'd0};
                inst    = line_sh[WORD_W-1:0];
            end
        end
    end

    assign hit   = |hit_vec;
    assign stall = (req && !hit) || (state != IDLE);

    // Victim pointer index follows whichever set the current state is working on.
    always_comb begin
        vs_idx = pc_idx;
        if (state == INIT || state == FLUSH) vs_idx = cnt;
        else if (state == REFILL)            vs_idx = fill_idx;
    end

    icache_victim_sel #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_victim (
        .clk    (clk),
        .idx    (vs_idx),
        .valid  (set_valid),
        .adv    (fill_we),
        .clr    (clr_we),
        .victim (victim)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    // Next state and per-state strobes; invalidates take priority over misses.
    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        inval_we  = 1'b0;
        fill_we   = 1'b0;
        go_refill = 1'b0;
        go_inval  = 1'b0;
        go_flush  = 1'b0;
        inv_ack   = 1'b0;
        bus_err   = 1'b0;
        cyc       = 1'b0;
        case (state)
            INIT: begin
                clr_we = 1'b1;
                if (last_set) state_nxt = IDLE;
            end
            IDLE: begin
                if (inv_req && inv_all) begin
                    go_flush  = 1'b1;
                    state_nxt = FLUSH;
                end else if (inv_req) begin
                    go_inval  = 1'b1;
                    state_nxt = INVAL;
                end else if (req && !hit) begin
                    go_refill = 1'b1;
                    state_nxt = REFILL;
                end
            end
            INVAL: begin
                inval_we  = 1'b1;
                inv_ack   = 1'b1;
                state_nxt = IDLE;
            end
            FLUSH: begin
                clr_we = 1'b1;
                if (last_set) begin
                    inv_ack   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            REFILL: begin
                cyc = 1'b1;
                if (wb.wb_err) begin
                    bus_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (wb.wb_ack) begin
                    fill_we   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign wb.wb_cyc = cyc;
    assign wb.wb_stb = cyc;
    assign wb.wb_adr = {fill_line, {OFS_W{1'b0}}};

    // Sweep counter and latched refill / invalidate targets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            fill_line <= '0;
            fill_way  <= '0;
            inv_idx   <= '0;
            inv_tag   <= '0;
        end else begin
            if (clr_we)        cnt <= cnt + IDX_W'(1);
            else if (go_flush) cnt <= '0;
            if (go_refill) begin
                fill_line <= pc[ADDR_W-1:OFS_W];
                fill_way  <= victim;
            end
            if (go_inval) begin
                inv_idx <= inv_addr[OFS_W +: IDX_W];
                inv_tag <= inv_addr[ADDR_W-1 -: TAG_W];
            end
        end
    end

    // Array writes: sweep clear, single-line invalidate, and whole-line fill.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (clr_we) valid_mem[w][cnt] <= 1'b0;
            if (inval_we && (tag_mem[w][inv_idx] == inv_tag)) valid_mem[w][inv_idx] <= 1'b0;
            if (fill_we && (PW'(w) == fill_way)) begin
                valid_mem[w][fill_idx] <= 1'b1;
                tag_mem[w][fill_idx]   <= fill_tag;
                data_mem[w][fill_idx]  <= wb.wb_dat_i;
            end
        end
    end

    // Two ways holding the same line would make the returned word ambiguous.
    always_ff @(posedge clk) begin
        if (rst && state == IDLE && req) assert ($onehot0(hit_vec));
    end

endmodule

// File: tb/tb_icache_nway_wb.sv
// tb/tb_icache_nway_wb.sv - directed self-checking bench for icache_nway_wb
module tb_icache_nway_wb;

    localparam int SETS = 512;
    localparam int LWRD = 16;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        req;
    logic [31:0] inst;
    logic        stall;
    logic [31:0] inv_addr;
    logic        inv_req;
    logic        inv_all;
    logic        inv_ack;
    logic        bus_err;

    icache_nway_wb_if #(.LINE_WORDS(LWRD)) wb_bus ();

    icache_nway_wb #(
        .WAYS       (2),
        .SETS       (SETS),
        .LINE_WORDS (LWRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .req      (req),
        .inst     (inst),
        .stall    (stall),
        .inv_addr (inv_addr),
        .inv_req  (inv_req),
        .inv_all  (inv_all),
        .inv_ack  (inv_ack),
        .bus_err  (bus_err),
        .wb       (wb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        exp_stall;
        logic [31:0] exp_inst;
        logic        chk_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a, input int k);
        return (a ^ 32'h1000) + 32'hA0 + 32'(k);
    endfunction

    function automatic logic [32*LWRD-1:0] line_of(input logic [31:0] a);
        logic [32*LWRD-1:0] l;
        l = '0;
        for (int k = 0; k < LWRD; k++) l[32*k +: 32] = word_of(a, k);
        return l;
    endfunction

    // Counts stalled negedges until wb_cyc appears; returns at that negedge.
    task automatic wait_cyc(output int n, output bit stalled);
        n       = 0;
        stalled = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (wb_bus.wb_cyc) break;
            if (!stall) stalled = 1'b0;
            n++;
        end
    endtask

    // Called at a negedge inside REFILL: drives the reply for one clock.
    task automatic respond(input bit ack, input bit err, input logic [31:0] a);
        wb_bus.wb_ack   = ack;
        wb_bus.wb_err   = err;
        wb_bus.wb_dat_i = line_of(a);
        #1;
        chk("bus_err_during_reply", {31'd0, bus_err}, {31'd0, err});
        @(posedge clk);
        #1;
        wb_bus.wb_ack = 1'b0;
        wb_bus.wb_err = 1'b0;
    endtask

    // One complete miss from IDLE: latency, line address, fill, then a hit.
    task automatic fill_line(input logic [31:0] a, input string nm);
        int n;
        bit s;
        @(posedge clk);
        #1;
        pc  = a;
        req = 1'b1;
        wait_cyc(n, s);
        chk({nm, "_miss_lat"}, 32'(n), 32'd1);
        chk({nm, "_miss_stall"}, {31'd0, s}, 32'd1);
        chk({nm, "_wb_adr"}, wb_bus.wb_adr, a & ~32'h3F);
        respond(1'b1, 1'b0, a);
        @(negedge clk);
        chk({nm, "_hit_stall"}, {31'd0, stall}, 32'd0);
        chk({nm, "_hit_inst"}, inst, word_of(a & ~32'h3F, 0));
    endtask

    initial begin
        int n;
        bit s;
        logic [31:0] miss_list [5];

        rst             = 1'b0;
        req             = 1'b0;
        pc              = '0;
        inv_addr        = '0;
        inv_req         = 1'b0;
        inv_all         = 1'b0;
        wb_bus.wb_ack   = 1'b0;
        wb_bus.wb_err   = 1'b0;
        wb_bus.wb_dat_i = '0;

        for (int i = 0; i < LWRD; i++) begin
            vec_t v;
            v.pc        = 32'h1000 + 32'(4 * i);
            v.req       = 1'b1;
            v.exp_stall = 1'b0;
            v.exp_inst  = 32'hA0 + 32'(i);
            v.chk_inst  = 1'b1;
            vecs.push_back(v);
        end
        begin
            vec_t v;
            v.pc        = 32'h9999_0000;
            v.req       = 1'b0;
            v.exp_stall = 1'b0;
            v.exp_inst  = 32'h0;
            v.chk_inst  = 1'b0;
            vecs.push_back(v);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd1);
        chk("rst_cyc", {31'd0, wb_bus.wb_cyc}, 32'd0);
        chk("rst_stb", {31'd0, wb_bus.wb_stb}, 32'd0);
        chk("rst_inv_ack", {31'd0, inv_ack}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);

        // 1: INIT sweep then first refill
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b1;
        pc  = 32'h1000;
        wait_cyc(n, s);
        chk("t1_init_lat", 32'(n), 32'(SETS + 1));
        chk("t1_stalled", {31'd0, s}, 32'd1);
        chk("t1_wb_adr", wb_bus.wb_adr, 32'h1000);
        chk("t1_wb_stb", {31'd0, wb_bus.wb_stb}, 32'd1);
        respond(1'b1, 1'b0, 32'h1000);
        @(negedge clk);
        chk("t1_stall", {31'd0, stall}, 32'd0);
        chk("t1_inst", inst, 32'hA0);

        // 2: sequential hits through the line, then an idle cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            pc  = vecs[i].pc;
            req = vecs[i].req;
            @(negedge clk);
            chk($sformatf("t2_stall_%0d", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            chk($sformatf("t2_cyc_%0d", i), {31'd0, wb_bus.wb_cyc}, 32'd0);
            if (vecs[i].chk_inst) chk($sformatf("t2_inst_%0d", i), inst, vecs[i].exp_inst);
        end

        // 3: three lines on one set of a 2-way cache
        fill_line(32'h0000_0000, "t3_a");
        fill_line(32'h0000_8000, "t3_b");
        fill_line(32'h0001_0000, "t3_c");
        @(posedge clk);
        #1;
        pc = 32'h0000_8004;
        @(negedge clk);
        chk("t3_b_rehit_stall", {31'd0, stall}, 32'd0);
        chk("t3_b_rehit_inst", inst, word_of(32'h8000, 1));
        fill_line(32'h0000_0000, "t3_a_evicted");

        // 4: single-line invalidate while a hit is in progress
        @(posedge clk);
        #1;
        pc = 32'h1000;
        @(negedge clk);
        chk("t4_prehit", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        inv_req  = 1'b1;
        inv_all  = 1'b0;
        inv_addr = 32'h1004;
        @(negedge clk);
        chk("t4_idle_stall", {31'd0, stall}, 32'd0);
        chk("t4_idle_ack", {31'd0, inv_ack}, 32'd0);
        @(negedge clk);
        chk("t4_inval_ack", {31'd0, inv_ack}, 32'd1);
        chk("t4_inval_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        inv_req = 1'b0;
        req     = 1'b0;
        @(negedge clk);
        chk("t4_ack_once", {31'd0, inv_ack}, 32'd0);
        @(posedge clk);
        #1;
        req = 1'b1;
        pc  = 32'h0001_0008;
        @(negedge clk);
        chk("t4_other_stall", {31'd0, stall}, 32'd0);
        chk("t4_other_inst", inst, word_of(32'h0001_0000, 2));
        fill_line(32'h1000, "t4_refetch");

        // 5: bus error (with ack also asserted) then a retried successful fill
        @(posedge clk);
        #1;
        pc = 32'h2000;
        wait_cyc(n, s);
        chk("t5_lat", 32'(n), 32'd1);
        chk("t5_wb_adr", wb_bus.wb_adr, 32'h2000);
        respond(1'b1, 1'b1, 32'h2000);
        @(negedge clk);
        chk("t5_err_once", {31'd0, bus_err}, 32'd0);
        chk("t5_no_write", {31'd0, stall}, 32'd1);
        wait_cyc(n, s);
        chk("t5_reissue", 32'(n), 32'd0);
        chk("t5_reissue_adr", wb_bus.wb_adr, 32'h2000);
        respond(1'b1, 1'b0, 32'h2000);
        @(negedge clk);
        chk("t5_hit_stall", {31'd0, stall}, 32'd0);
        chk("t5_hit_inst", inst, word_of(32'h2000, 0));
        @(posedge clk);
        #1;
        pc = 32'h203C;
        @(negedge clk);
        chk("t5_last_word", inst, word_of(32'h2000, 15));

        // 6: invalidate-all raised during a refill
        @(posedge clk);
        #1;
        pc = 32'h3000;
        wait_cyc(n, s);
        chk("t6_lat", 32'(n), 32'd1);
        inv_req  = 1'b1;
        inv_all  = 1'b1;
        inv_addr = 32'h1234_5678;
        @(negedge clk);
        chk("t6_hold_cyc", {31'd0, wb_bus.wb_cyc}, 32'd1);
        chk("t6_hold_ack", {31'd0, inv_ack}, 32'd0);
        respond(1'b1, 1'b0, 32'h3000);
        @(negedge clk);
        chk("t6_fill_first_stall", {31'd0, stall}, 32'd0);
        chk("t6_fill_first_inst", inst, word_of(32'h3000, 0));
        n = 0;
        s = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!stall) s = 1'b0;
            if (inv_ack) break;
            n++;
        end
        chk("t6_flush_len", 32'(n), 32'(SETS - 1));
        chk("t6_flush_stall", {31'd0, s}, 32'd1);
        @(posedge clk);
        #1;
        inv_req = 1'b0;
        inv_all = 1'b0;
        req     = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (inv_ack) n++;
        end
        chk("t6_ack_once", 32'(n), 32'd0);
        miss_list[0] = 32'h1000;
        miss_list[1] = 32'h0000;
        miss_list[2] = 32'h0001_0000;
        miss_list[3] = 32'h2000;
        miss_list[4] = 32'h3000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            pc  = miss_list[i];
            req = 1'b1;
            @(negedge clk);
            chk($sformatf("t6_flushed_%0d", i), {31'd0, stall}, 32'd1);
            req = 1'b0;
        end

        // Reset during a refill drops the bus cycle at once
        @(posedge clk);
        #1;
        pc  = 32'h4000;
        req = 1'b1;
        wait_cyc(n, s);
        chk("rr_cyc_up", {31'd0, wb_bus.wb_cyc}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rr_cyc_drop", {31'd0, wb_bus.wb_cyc}, 32'd0);
        chk("rr_stall", {31'd0, stall}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
